ps2_keyboard_to_ascii: RTL and testbench
========================================

PS2_KEYBOARD_TO_ASCII -- requirements
Module: ps2_keyboard_to_ascii

Interface
REQ-001 Parameter clk_freq, default 50_000_000: system clock frequency in Hz; sets the frame idle timeout.
REQ-002 Parameter ps2_debounce_counter_size, default 8: width of the debounce counter; a line is stable after 2^N-1 unchanged clk cycles.
REQ-003 Port clk, input, 1: the single system clock, rising-edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port ps2_clk, input, 1: keyboard clock line, asynchronous to clk.
REQ-006 Port ps2_data, input, 1: keyboard data line, asynchronous to clk.
REQ-007 Port ascii_new, output, 1: one-clk pulse; ascii_code and key_pressed are valid for a new event.
REQ-008 Port key_pressed, output, 1: 1 = make event, 0 = break (release) event.
REQ-009 Port ascii_code, output, 8: translated ASCII; bit 7 is always 0.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass a 2-flop synchronizer, then a debouncer: output updates only after the synchronized value has been constant for 2^ps2_debounce_counter_size-1 cycles.
REQ-011 The receiver SHALL sample ps2_data on each falling edge of debounced ps2_clk, shifting 11 bits: start(0), 8 data bits LSB-first, odd parity, stop(1).
REQ-012 A frame SHALL be complete when debounced ps2_clk stays high for clk_freq/18000 cycles (~55 us) after a falling edge.
REQ-013 On completion, if start=0, stop=1 and odd parity is correct, the receiver SHALL emit the 8-bit scan code with a one-cycle code_new strobe; otherwise the frame SHALL be discarded silently.
REQ-014 Translator FSM states: READY, NEW_CODE, TRANSLATE, OUTPUT; READY->NEW_CODE on code_new; NEW_CODE->TRANSLATE next cycle; TRANSLATE->OUTPUT when the code maps to ASCII, else ->READY; OUTPUT->READY after asserting ascii_new.
REQ-015 ascii_new SHALL go high exactly 3 clk after the code_new strobe, for exactly one cycle.
REQ-016 0xF0 SHALL set a break flag and 0xE0 an extended flag; neither produces output, and both flags SHALL clear after the next non-prefix code is processed.
REQ-017 key_pressed SHALL equal NOT(break flag) for the output event; break events of mapped keys SHALL also pulse ascii_new.
REQ-018 Left shift (0x12) and right shift (0x59) SHALL set shift on make and clear it on break; ctrl (0x14) likewise; caps lock (0x58) SHALL toggle on make only.
REQ-019 Letter keys: lower case when shift XOR caps = 0, upper case otherwise; ctrl+letter SHALL give 0x01..0x1A and overrides case.
REQ-020 Digit/symbol row SHALL use US layout; shift selects the symbol (0x16 gives '1' or '!'); caps SHALL NOT affect non-letters.
REQ-021 Fixed maps: space 0x29->0x20, enter 0x5A->0x0D, backspace 0x66->0x08, tab 0x0D->0x09, esc 0x76->0x1B.
REQ-022 Modifier keys, unmapped codes, and any extended (E0) code except keypad enter/'/' SHALL produce no ascii_new.
REQ-023 ascii_code and key_pressed SHALL hold their last value between pulses.

Reset
REQ-024 Reset SHALL asynchronously clear: ascii_new=0, key_pressed=0, ascii_code=0x00, all flags (shift, ctrl, caps, break, extended), shift register, and counters; FSM->READY.
REQ-025 A partial frame in progress at reset SHALL be discarded; reception resumes with the next start bit after reset release.

Structure
REQ-026 Package ps2_pkg SHALL hold the FSM state enum, prefix codes (0xE0, 0xF0), modifier scan codes, and the timeout constant function.
REQ-027 Debounce plus frame reception SHALL be a sub-module ps2_keyboard (outputs: 8-bit code, code_new); translation SHALL be in the top module.

Verification
REQ-028 Frame 0x1C with correct parity -> one ascii_new pulse, ascii_code=0x61, key_pressed=1, exactly 3 clk after code_new.
REQ-029 0x12, 0x1C, F0 1C, F0 12 -> 0x41 with key_pressed=1, then 0x41 with key_pressed=0; no pulse for the shift codes.
REQ-030 0x58 make, then 0x1C -> 0x41; shift+0x1C while caps is on -> 0x61; 0x16 with caps on -> 0x31.
REQ-031 0x14 held, then 0x21 ('c') -> 0x03; 0x5A -> 0x0D.
REQ-032 Frame 0x1C with a wrong parity bit, or a ps2_clk glitch shorter than the debounce window -> no ascii_new, no state change.
REQ-033 Reset asserted mid-frame, then a clean 0x29 frame -> outputs 0 during reset, then ascii_code=0x20 pulse.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and scan-code translator.
package ps2_pkg;

   // Translator sequencing: latch the code, resolve it, then present the result.
   typedef enum logic [1:0] {
      READY,
      NEW_CODE,
      TRANSLATE,
      OUTPUT
   } xlat_state_t;

   // Prefix codes that modify how the following code is interpreted.
   localparam logic [7:0] CODE_EXTENDED = 8'hE0;
   localparam logic [7:0] CODE_BREAK    = 8'hF0;

   // Modifier keys (scan code set 2).
   localparam logic [7:0] CODE_LSHIFT = 8'h12;
   localparam logic [7:0] CODE_RSHIFT = 8'h59;
   localparam logic [7:0] CODE_CTRL   = 8'h14;
   localparam logic [7:0] CODE_CAPS   = 8'h58;

   // Result of a scan-code lookup: valid flags codes that produce a character.
   typedef struct packed {
      logic       valid;
      logic [6:0] ch;
   } ascii_lookup_t;

   // Idle time (in clk cycles) that marks the end of a frame, about 55 us.
   function automatic int unsigned frame_timeout_cycles(input int unsigned clk_freq);
      return clk_freq / 18000;
   endfunction

endpackage

// File: rtl/ps2_keyboard.sv
// PS/2 front end: synchronizes and debounces both lines, shifts in 11-bit frames on
// falling clock edges and emits each parity-checked scan code with a one-cycle strobe.
module ps2_keyboard
   import ps2_pkg::*;
#(
   parameter int unsigned clk_freq                  = 50_000_000,
   parameter int unsigned ps2_debounce_counter_size = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] code,
   output logic       code_new
);

   localparam int unsigned TIMEOUT = frame_timeout_cycles(clk_freq);
   localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 1);
   localparam int unsigned DB_W    = ps2_debounce_counter_size;

   // Bit 0 carries the clock line, bit 1 the data line.
   logic [1:0]           raw;
   logic [1:0]           sync1_q, sync2_q, last_q, db_q;
   logic [1:0][DB_W-1:0] db_cnt_q;

   logic                 db_clk_prev_q;
   logic                 fall;
   logic [10:0]          frame_q;
   logic [3:0]           bit_cnt_q;
   logic [IDLE_W-1:0]    idle_cnt_q;
   logic                 frame_valid;

   assign raw = {ps2_data, ps2_clk};

   // Two-flop synchronizer, then a per-line stability counter gating the debounced value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: lines idle high, so the synchronizer and debounced outputs reset to 1;
         // resetting them to 0 would fake a falling edge right after reset release.
         sync1_q  <= '1;
         sync2_q  <= '1;
         last_q   <= '1;
         db_q     <= '1;
         db_cnt_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples
         // the pre-edge value of its neighbours, exactly like the hardware.
         sync1_q <= raw;
         sync2_q <= sync1_q;
         last_q  <= sync2_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != last_q[i])
               db_cnt_q[i] <= '0;
            else if (db_cnt_q[i] != '1)
               db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
            else
               db_q[i] <= last_q[i];
         end
      end
   end

   assign fall = db_clk_prev_q & ~db_q[0];

   // Start=0, stop=1, odd parity over data+parity, and exactly eleven bits received.
   assign frame_valid = (bit_cnt_q == 4'd11) && !frame_q[0] && frame_q[10] && (^frame_q[9:1]);

   // Shift bits on falling edges; an idle-high timeout closes the frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_clk_prev_q <= 1'b1;
         frame_q       <= '0;
         bit_cnt_q     <= '0;
         idle_cnt_q    <= '0;
         code          <= '0;
         code_new      <= 1'b0;
      end else begin
         db_clk_prev_q <= db_q[0];
         code_new      <= 1'b0;
         if (fall) begin
            frame_q    <= {db_q[1], frame_q[10:1]};
            idle_cnt_q <= '0;
            if (bit_cnt_q != 4'hF)
               bit_cnt_q <= bit_cnt_q + 4'd1;
         end else if (!db_q[0]) begin
            idle_cnt_q <= '0;
         end else if (idle_cnt_q != IDLE_W'(TIMEOUT)) begin
            idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
            if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
               bit_cnt_q <= '0;
               if (frame_valid) begin
                  code     <= frame_q[8:1];
                  code_new <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/ps2_keyboard_to_ascii.sv
// PS/2 keyboard to ASCII: tracks prefixes and modifiers and translates set-2 scan codes
// into ASCII make/break events with a one-cycle ascii_new pulse.
module ps2_keyboard_to_ascii
   import ps2_pkg::*;
#(
   parameter int unsigned clk_freq                  = 50_000_000,
   parameter int unsigned ps2_debounce_counter_size = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ascii_new,
   output logic       key_pressed,
   output logic [7:0] ascii_code
);

   logic [7:0]    code;
   logic          code_new;
   logic [7:0]    code_q;
   xlat_state_t   state_q, state_d;
   logic          break_q, ext_q, shift_q, ctrl_q, caps_q;
   ascii_lookup_t lookup;
   logic [6:0]    letter;
   logic [13:0]   symbol;

   ps2_keyboard #(
      .clk_freq                 (clk_freq),
      .ps2_debounce_counter_size(ps2_debounce_counter_size)
   ) u_kbd (
      .clk     (clk),
      .reset   (reset),
      .ps2_clk (ps2_clk),
      .ps2_data(ps2_data),
      .code    (code),
      .code_new(code_new)
   );

   // Lower-case letter for a letter key, 0 otherwise.
   function automatic logic [6:0] letter_of(input logic [7:0] c);
      case (c)
         8'h1C: return 7'h61;  8'h32: return 7'h62;  8'h21: return 7'h63;  8'h23: return 7'h64;
         8'h24: return 7'h65;  8'h2B: return 7'h66;  8'h34: return 7'h67;  8'h33: return 7'h68;
         8'h43: return 7'h69;  8'h3B: return 7'h6A;  8'h42: return 7'h6B;  8'h4B: return 7'h6C;
         8'h3A: return 7'h6D;  8'h31: return 7'h6E;  8'h44: return 7'h6F;  8'h4D: return 7'h70;
         8'h15: return 7'h71;  8'h2D: return 7'h72;  8'h1B: return 7'h73;  8'h2C: return 7'h74;
         8'h3C: return 7'h75;  8'h2A: return 7'h76;  8'h1D: return 7'h77;  8'h22: return 7'h78;
         8'h35: return 7'h79;  8'h1A: return 7'h7A;
         default: return 7'h00;
      endcase
   endfunction

   // US digit/symbol row: {unshifted, shifted}, 0 when the key is not on it.
   function automatic logic [13:0] symbol_of(input logic [7:0] c);
      case (c)
         8'h0E: return {7'h60, 7'h7E};  8'h16: return {7'h31, 7'h21};  8'h1E: return {7'h32, 7'h40};
         8'h26: return {7'h33, 7'h23};  8'h25: return {7'h34, 7'h24};  8'h2E: return {7'h35, 7'h25};
         8'h36: return {7'h36, 7'h5E};  8'h3D: return {7'h37, 7'h26};  8'h3E: return {7'h38, 7'h2A};
         8'h46: return {7'h39, 7'h28};  8'h45: return {7'h30, 7'h29};  8'h4E: return {7'h2D, 7'h5F};
         8'h55: return {7'h3D, 7'h2B};  8'h54: return {7'h5B, 7'h7B};  8'h5B: return {7'h5D, 7'h7D};
         8'h5D: return {7'h5C, 7'h7C};  8'h4C: return {7'h3B, 7'h3A};  8'h52: return {7'h27, 7'h22};
         8'h41: return {7'h2C, 7'h3C};  8'h49: return {7'h2E, 7'h3E};  8'h4A: return {7'h2F, 7'h3F};
         default: return 14'h0000;
      endcase
   endfunction

   // Resolve the latched code against the current prefix and modifier flags.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      lookup = '0;
      letter = letter_of(code_q);
      symbol = symbol_of(code_q);
      if (ext_q) begin
         if (code_q == 8'h5A)      lookup = '{valid: 1'b1, ch: 7'h0D};
         else if (code_q == 8'h4A) lookup = '{valid: 1'b1, ch: 7'h2F};
      end else if (letter != 7'h00) begin
         lookup.valid = 1'b1;
         if (ctrl_q)                lookup.ch = letter - 7'h60;
         else if (shift_q ^ caps_q) lookup.ch = letter - 7'h20;
         else                       lookup.ch = letter;
      end else if (symbol != 14'h0000) begin
         lookup.valid = 1'b1;
         lookup.ch    = shift_q ? symbol[6:0] : symbol[13:7];
      end else begin
         case (code_q)
            8'h29:   lookup = '{valid: 1'b1, ch: 7'h20};
            8'h5A:   lookup = '{valid: 1'b1, ch: 7'h0D};
            8'h66:   lookup = '{valid: 1'b1, ch: 7'h08};
            8'h0D:   lookup = '{valid: 1'b1, ch: 7'h09};
            8'h76:   lookup = '{valid: 1'b1, ch: 7'h1B};
            default: lookup = '0;
         endcase
      end
   end

   // Translator next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         READY:     if (code_new) state_d = NEW_CODE;
         NEW_CODE:  state_d = TRANSLATE;
         TRANSLATE: state_d = lookup.valid ? OUTPUT : READY;
         OUTPUT:    state_d = READY;
         default:   state_d = READY;
      endcase
   end

   // Translator state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= READY;
      else       state_q <= state_d;
   end

   assign ascii_new = (state_q == OUTPUT);

   // Latch the code, update prefix/modifier flags and register the translated event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         code_q      <= '0;
         break_q     <= 1'b0;
         ext_q       <= 1'b0;
         shift_q     <= 1'b0;
         ctrl_q      <= 1'b0;
         caps_q      <= 1'b0;
         ascii_code  <= '0;
         key_pressed <= 1'b0;
      end else begin
         if (state_q == READY && code_new)
            code_q <= code;
         if (state_q == TRANSLATE) begin
            if (code_q == CODE_BREAK) begin
               break_q <= 1'b1;
            end else if (code_q == CODE_EXTENDED) begin
               ext_q <= 1'b1;
            end else begin
               break_q <= 1'b0;
               ext_q   <= 1'b0;
               // E0 12 is a fake shift sent around some extended keys; ignore it.
               if (!ext_q && (code_q == CODE_LSHIFT || code_q == CODE_RSHIFT))
                  shift_q <= !break_q;
               if (code_q == CODE_CTRL)
                  ctrl_q <= !break_q;
               if (!ext_q && code_q == CODE_CAPS && !break_q)
                  caps_q <= !caps_q;
               if (lookup.valid) begin
                  ascii_code  <= {1'b0, lookup.ch};
                  key_pressed <= !break_q;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_to_ascii.sv
// Bench for ps2_keyboard_to_ascii: table of single scan-code frames with expected
// pulse/ASCII/make-break, plus hand sequences for parity error, clock glitch and reset.
module tb_ps2_keyboard_to_ascii;

   localparam int unsigned CLK_FREQ = 1_800_000;  // frame timeout of 100 clk
   localparam int unsigned DB_SIZE  = 3;          // debounce window of 7 clk
   localparam int          HALF     = 20;         // PS/2 half bit period in clk
   localparam int          SETTLE   = 160;        // idle wait after a frame

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic       ascii_new;
   logic       key_pressed;
   logic [7:0] ascii_code;

   int total = 0;
   int bad   = 0;

   int cyc       = 0;
   int cn_cyc    = -100;
   int pulse_cnt = 0;
   int wide_cnt  = 0;
   int last_lat  = -1;
   logic prev_new = 1'b0;

   typedef struct {
      logic [7:0] code;
      logic       exp_pulse;
      logic [7:0] exp_ascii;
      logic       exp_pressed;
   } vec_t;

   vec_t vecs[$];

   ps2_keyboard_to_ascii #(
      .clk_freq                 (CLK_FREQ),
      .ps2_debounce_counter_size(DB_SIZE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .ascii_new  (ascii_new),
      .key_pressed(key_pressed),
      .ascii_code (ascii_code)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Count ascii_new pulses, their distance from code_new and any pulse wider than one clk.
   always @(negedge clk) begin
      if (dut.u_kbd.code_new) cn_cyc = cyc;
      if (ascii_new) begin
         pulse_cnt = pulse_cnt + 1;
         last_lat  = cyc - cn_cyc;
         if (prev_new) wide_cnt = wide_cnt + 1;
      end
      prev_new = ascii_new;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive the first nbits of a frame; bad flips the parity bit.
   task automatic send_bits(input logic [7:0] c, input logic bad_par, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~(^c)) ^ bad_par, c, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic run_frame(input logic [7:0] c, input logic bad_par);
      pulse_cnt = 0;
      wide_cnt  = 0;
      last_lat  = -1;
      send_bits(c, bad_par, 11);
      repeat (SETTLE) @(negedge clk);
   endtask

   function automatic vec_t v(input logic [7:0] c, input logic p, input logic [7:0] a, input logic k);
      vec_t r;
      r.code = c; r.exp_pulse = p; r.exp_ascii = a; r.exp_pressed = k;
      return r;
   endfunction

   initial begin
      // code, pulse expected, ascii_code (held value when no pulse), key_pressed
      vecs.push_back(v(8'h1C, 1, 8'h61, 1));  vecs.push_back(v(8'hF0, 0, 8'h61, 1));
      vecs.push_back(v(8'h1C, 1, 8'h61, 0));  vecs.push_back(v(8'h12, 0, 8'h61, 0));
      vecs.push_back(v(8'h1C, 1, 8'h41, 1));  vecs.push_back(v(8'hF0, 0, 8'h41, 1));
      vecs.push_back(v(8'h1C, 1, 8'h41, 0));  vecs.push_back(v(8'hF0, 0, 8'h41, 0));
      vecs.push_back(v(8'h12, 0, 8'h41, 0));  vecs.push_back(v(8'h1C, 1, 8'h61, 1));
      vecs.push_back(v(8'h58, 0, 8'h61, 1));  vecs.push_back(v(8'h1C, 1, 8'h41, 1));
      vecs.push_back(v(8'h12, 0, 8'h41, 1));  vecs.push_back(v(8'h1C, 1, 8'h61, 1));
      vecs.push_back(v(8'h16, 1, 8'h21, 1));  vecs.push_back(v(8'hF0, 0, 8'h21, 1));
      vecs.push_back(v(8'h12, 0, 8'h21, 1));  vecs.push_back(v(8'h16, 1, 8'h31, 1));
      vecs.push_back(v(8'hF0, 0, 8'h31, 1));  vecs.push_back(v(8'h58, 0, 8'h31, 1));
      vecs.push_back(v(8'h1C, 1, 8'h41, 1));  vecs.push_back(v(8'h58, 0, 8'h41, 1));
      vecs.push_back(v(8'h1C, 1, 8'h61, 1));  vecs.push_back(v(8'h14, 0, 8'h61, 1));
      vecs.push_back(v(8'h21, 1, 8'h03, 1));  vecs.push_back(v(8'hF0, 0, 8'h03, 1));
      vecs.push_back(v(8'h14, 0, 8'h03, 1));  vecs.push_back(v(8'h21, 1, 8'h63, 1));
      vecs.push_back(v(8'h5A, 1, 8'h0D, 1));  vecs.push_back(v(8'h29, 1, 8'h20, 1));
      vecs.push_back(v(8'h66, 1, 8'h08, 1));  vecs.push_back(v(8'h0D, 1, 8'h09, 1));
      vecs.push_back(v(8'h76, 1, 8'h1B, 1));  vecs.push_back(v(8'hE0, 0, 8'h1B, 1));
      vecs.push_back(v(8'h4A, 1, 8'h2F, 1));  vecs.push_back(v(8'hE0, 0, 8'h2F, 1));
      vecs.push_back(v(8'h75, 0, 8'h2F, 1));  vecs.push_back(v(8'h75, 0, 8'h2F, 1));
      vecs.push_back(v(8'h4E, 1, 8'h2D, 1));  vecs.push_back(v(8'hE0, 0, 8'h2D, 1));
      vecs.push_back(v(8'hF0, 0, 8'h2D, 1));  vecs.push_back(v(8'h5A, 1, 8'h0D, 0));
      vecs.push_back(v(8'h59, 0, 8'h0D, 0));  vecs.push_back(v(8'h4E, 1, 8'h5F, 1));
      vecs.push_back(v(8'hF0, 0, 8'h5F, 1));  vecs.push_back(v(8'h59, 0, 8'h5F, 1));

      // Reset state.
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_ascii_new", 32'(ascii_new), 32'd0);
      check("reset_ascii_code", 32'(ascii_code), 32'h00);
      check("reset_key_pressed", 32'(key_pressed), 32'd0);
      reset = 1'b0;
      repeat (SETTLE) @(negedge clk);

      // Table-driven single-frame vectors.
      foreach (vecs[i]) begin
         run_frame(vecs[i].code, 1'b0);
         check($sformatf("row%0d_code%02h_pulses", i, vecs[i].code), 32'(pulse_cnt), 32'(vecs[i].exp_pulse));
         check($sformatf("row%0d_code%02h_ascii", i, vecs[i].code), 32'(ascii_code), 32'(vecs[i].exp_ascii));
         check($sformatf("row%0d_code%02h_pressed", i, vecs[i].code), 32'(key_pressed), 32'(vecs[i].exp_pressed));
         if (vecs[i].exp_pulse) begin
            check($sformatf("row%0d_latency", i), 32'(last_lat), 32'd3);
            check($sformatf("row%0d_pulse_width", i), 32'(wide_cnt), 32'd0);
         end
      end

      // Wrong parity: frame dropped, outputs held.
      run_frame(8'h1C, 1'b1);
      check("bad_parity_pulses", 32'(pulse_cnt), 32'd0);
      check("bad_parity_ascii_held", 32'(ascii_code), 32'h5F);

      // Clock glitch shorter than the debounce window: no bit shifted in.
      pulse_cnt = 0;
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (SETTLE) @(negedge clk);
      check("glitch_pulses", 32'(pulse_cnt), 32'd0);
      run_frame(8'h1C, 1'b0);
      check("after_glitch_pulses", 32'(pulse_cnt), 32'd1);
      check("after_glitch_ascii", 32'(ascii_code), 32'h61);
      check("after_glitch_pressed", 32'(key_pressed), 32'd1);

      // Reset in the middle of a frame while shift is held.
      run_frame(8'h12, 1'b0);
      send_bits(8'h1C, 1'b0, 5);
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      check("midreset_ascii_new", 32'(ascii_new), 32'd0);
      check("midreset_ascii_code", 32'(ascii_code), 32'h00);
      check("midreset_key_pressed", 32'(key_pressed), 32'd0);
      reset = 1'b0;
      repeat (SETTLE) @(negedge clk);
      run_frame(8'h29, 1'b0);
      check("post_reset_space_pulses", 32'(pulse_cnt), 32'd1);
      check("post_reset_space_ascii", 32'(ascii_code), 32'h20);
      check("post_reset_space_pressed", 32'(key_pressed), 32'd1);
      check("post_reset_space_latency", 32'(last_lat), 32'd3);
      run_frame(8'h1C, 1'b0);
      check("post_reset_shift_cleared", 32'(ascii_code), 32'h61);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
